// File: rtl/operand_sequencer.sv
// operand_sequencer: captures operands A and B from slide switches on debounced
// button presses, drives them to an external 4-bit adder, then latches the
// adder's sum, carry-out and zero flag for display.
//
// Optional feature macro: SUB_MODE_EN
//   When defined, input sub_i is added. If sub_i=1 on the B capture edge, the
//   two's complement of sw is stored in b_o so the adder computes A-B.
//   co_o=1 then means no borrow occurred.
//
// Handshake/timing note: there is no valid/ready pair on the inputs. valid_o
// rises on the S_EXEC edge together with res_o/co_o/zero_o and stays high
// until the next press in S_SHOW. Results only change on the S_EXEC edge.
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic [3:0] sum_i,
    input  logic       co_i,
    input  logic       zero_i,
`ifdef SUB_MODE_EN
    input  logic       sub_i,
`endif
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       ci_o,
    output logic [3:0] res_o,
    output logic       co_o,
    output logic       zero_o,
    output logic       valid_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [3:0]       r_a;
    logic [3:0]       r_b;
    logic [3:0]       r_res;
    logic             r_co;
    logic             r_zero;
    logic             r_valid;

    logic             w_press;
    logic [3:0]       w_b_next;

    // Rising edge of the debounced level; a held button gives one pulse only.
    assign w_press = r_db & ~r_db_d;

`ifdef SUB_MODE_EN
    assign w_b_next = sub_i ? (~sw + 4'd1) : sw;
`else
    assign w_b_next = sw;
`endif

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: the level must differ for DEBOUNCE_CYCLES cycles before it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_db   <= 1'b0;
            r_db_d <= 1'b0;
        end else begin
            r_db_d <= r_db;
            if (r_sync2 != r_db) begin
                if (r_cnt == C_CNT_MAX) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Operand capture / execute / show sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_res   <= 4'd0;
            r_co    <= 1'b0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_A: begin
                    if (w_press) begin
                        r_a     <= sw;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_press) begin
                        r_b     <= w_b_next;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for a full cycle; adder has settled.
                    r_res   <= sum_i;
                    r_co    <= co_i;
                    r_zero  <= zero_i;
                    r_valid <= 1'b1;
                    r_state <= S_SHOW;
                end
                S_SHOW: begin
                    // This press only clears the display; sw is not captured.
                    if (w_press) begin
                        r_valid <= 1'b0;
                        r_state <= S_A;
                    end
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign a_o     = r_a;
    assign b_o     = r_b;
    assign ci_o    = 1'b0;
    assign res_o   = r_res;
    assign co_o    = r_co;
    assign zero_o  = r_zero;
    assign valid_o = r_valid;
    assign state_o = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Testbench for operand_sequencer with a behavioural 4-bit adder as the load.
// Results are checked by a monitor that pops expected {res,co,zero} values
// whenever valid_o rises; other observables are checked directly.
module tb_operand_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       btn;
    logic [3:0] sum_i;
    logic       co_i;
    logic       zero_i;
    logic       sub_i;
    logic [3:0] a_o;
    logic [3:0] b_o;
    logic       ci_o;
    logic [3:0] res_o;
    logic       co_o;
    logic       zero_o;
    logic       valid_o;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];
    logic       valid_prev = 1'b0;

    operand_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn(btn),
        .sum_i(sum_i),
        .co_i(co_i),
        .zero_i(zero_i),
`ifdef SUB_MODE_EN
        .sub_i(sub_i),
`endif
        .a_o(a_o),
        .b_o(b_o),
        .ci_o(ci_o),
        .res_o(res_o),
        .co_o(co_o),
        .zero_o(zero_o),
        .valid_o(valid_o),
        .state_o(state_o)
    );

    // Behavioural ripple adder driven by the DUT operands.
    assign {co_i, sum_i} = {1'b0, a_o} + {1'b0, b_o} + {4'b0, ci_o};
    assign zero_i = (sum_i == 4'd0);

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no end of test, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] val);
        sw  = val;
        btn = 1'b1;
        idle(20);
        btn = 1'b0;
        idle(20);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
        idle(1);
    endtask

    // Scoreboard monitor: compare latched results on each rising valid_o.
    always @(negedge clk) begin
        if (valid_o && !valid_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL result_unexpected: got res=%0d co=%0d zero=%0d, required none",
                         res_o, co_o, zero_o);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                if ({res_o, co_o, zero_o} !== e) begin
                    n_errors++;
                    $display("FAIL result: got res=%0d co=%0d zero=%0d, required res=%0d co=%0d zero=%0d",
                             res_o, co_o, zero_o, e[5:2], e[1], e[0]);
                end
            end
        end
        valid_prev = valid_o;
    end

    initial begin
        rst   = 1'b1;
        sw    = 4'd0;
        btn   = 1'b0;
        sub_i = 1'b0;
        idle(3);
        rst = 1'b0;
        idle(1);

        check("rst_state", 8'(state_o), 8'd0);
        check("rst_a", 8'(a_o), 8'd0);
        check("rst_b", 8'(b_o), 8'd0);
        check("rst_res", 8'(res_o), 8'd0);
        check("rst_co", 8'(co_o), 8'd0);
        check("rst_zero", 8'(zero_o), 8'd0);
        check("rst_valid", 8'(valid_o), 8'd0);
        check("rst_ci", 8'(ci_o), 8'd0);

        // 3 + 5 = 8
        press(4'd3);
        check("a_cap3", 8'(a_o), 8'd3);
        check("state_b", 8'(state_o), 8'd1);
        sw = 4'd15;
        idle(3);
        check("a_hold_sw", 8'(a_o), 8'd3);
        exp_q.push_back({4'd8, 1'b0, 1'b0});
        press(4'd5);
        check("b_cap5", 8'(b_o), 8'd5);
        check("state_show1", 8'(state_o), 8'd3);
        check("valid_show1", 8'(valid_o), 8'd1);
        check("ci_const", 8'(ci_o), 8'd0);

        // Press in S_SHOW returns to S_A without capturing
        press(4'd12);
        check("valid_clr1", 8'(valid_o), 8'd0);
        check("state_a1", 8'(state_o), 8'd0);
        check("res_hold8", 8'(res_o), 8'd8);
        check("a_retain", 8'(a_o), 8'd3);

        // 9 + 7 = 16 -> 0, carry, zero
        press(4'd9);
        exp_q.push_back({4'd0, 1'b1, 1'b1});
        press(4'd7);
        check("state_show2", 8'(state_o), 8'd3);
        press(4'd1);
        check("valid_clr2", 8'(valid_o), 8'd0);
        check("state_a2", 8'(state_o), 8'd0);
        check("res_hold0", 8'(res_o), 8'd0);

        // Two-cycle glitch must not count as a press
        sw  = 4'd6;
        btn = 1'b1;
        idle(2);
        btn = 1'b0;
        idle(20);
        check("glitch_state", 8'(state_o), 8'd0);

        // Long hold gives exactly one advance
        btn = 1'b1;
        idle(100);
        btn = 1'b0;
        idle(20);
        check("hold_state", 8'(state_o), 8'd1);
        check("hold_a6", 8'(a_o), 8'd6);

        // Reset while in S_B
        do_reset(1);
        check("midrst_state", 8'(state_o), 8'd0);
        check("midrst_a", 8'(a_o), 8'd0);
        check("midrst_valid", 8'(valid_o), 8'd0);
        press(4'd2);
        check("post_rst_a", 8'(a_o), 8'd2);
        check("post_rst_state", 8'(state_o), 8'd1);

        // Reset coinciding with the press pulse in S_A
        do_reset(1);
        sw  = 4'd9;
        btn = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        btn = 1'b0;
        idle(1);
        rst = 1'b0;
        idle(20);
        check("rst_press_state", 8'(state_o), 8'd0);
        check("rst_press_a", 8'(a_o), 8'd0);

        // 15 + 15 = 30 -> 14, carry
        press(4'd15);
        exp_q.push_back({4'd14, 1'b1, 1'b0});
        press(4'd15);
        check("state_show3", 8'(state_o), 8'd3);
        press(4'd0);

`ifdef SUB_MODE_EN
        // 5 - 3 = 2, no borrow
        press(4'd5);
        sub_i = 1'b1;
        exp_q.push_back({4'd2, 1'b1, 1'b0});
        press(4'd3);
        check("sub_b13", 8'(b_o), 8'd13);
        check("sub_ci", 8'(ci_o), 8'd0);
        press(4'd0);
        // 3 - 5 = -2 -> 14, borrow
        press(4'd3);
        exp_q.push_back({4'd14, 1'b0, 1'b0});
        press(4'd5);
        check("sub_b11", 8'(b_o), 8'd11);
        press(4'd0);
        sub_i = 1'b0;
`endif

        idle(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL results_pending: got %0d left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Upstream/downstream companion of the 4-bit ripple adder on the lab board.
- Debounces a single push-button and captures operands A and B in turn from four slide switches.
- Drives the adder operand inputs, then latches the adder's sum, carry-out and zero flag for display.
- Sits between the board I/O (switches, button, LEDs) and the combinational adder.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change (5 ms at 50 MHz); minimum 2.
- CNT_W, 18, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sw  input  4  operand value from slide switches
- btn  input  1  raw asynchronous push-button, active-high
- sum_i  input  4  adder sum output
- co_i  input  1  adder carry-out
- zero_i  input  1  adder zero flag
- a_o  output  4  operand A to adder
- b_o  output  4  operand B to adder
- ci_o  output  1  carry-in to adder, constant 0
- res_o  output  4  latched sum
- co_o  output  1  latched carry-out
- zero_o  output  1  latched zero flag
- valid_o  output  1  latched result is valid
- state_o  output  2  current FSM state, for LEDs

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - a_o, b_o, res_o = 0
  - co_o, zero_o, valid_o, ci_o = 0
  - state = S_A (00)
  - debounce counter = 0, debounced level = 0, synchroniser flops = 0
- Synchroniser: btn passes through 2 flops before any use.
- Debounce:
  - Counter increments each cycle the synchronised level differs from the debounced level.
  - Counter clears whenever the two levels are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- Press pulse:
  - One-cycle pulse on each 0->1 transition of the debounced level.
  - A held button produces exactly one pulse; release produces none.
- FSM, state_o encoding S_A=00, S_B=01, S_EXEC=10, S_SHOW=11:
  - S_A: on press, a_o <= sw and go to S_B.
  - S_B: on press, b_o <= sw and go to S_EXEC.
  - S_EXEC: unconditional, one cycle; res_o <= sum_i, co_o <= co_i, zero_o <= zero_i, valid_o <= 1; go to S_SHOW.
  - S_SHOW: hold all results. On press: valid_o <= 0, a_o and b_o retained, go to S_A; sw is not captured on this press.
- Latency:
  - Press pulse in S_B at edge n: b_o is updated at edge n+1.
  - Adder settles combinationally during S_EXEC.
  - res_o and valid_o are updated at edge n+2.
- Operands: a_o and b_o are driven continuously from registers. sw is sampled only on the capturing edge; later sw changes have no effect.
- Output timing: res_o, co_o and zero_o change only on the S_EXEC edge (or on reset). Between results they hold their last value.
- Simultaneous events: rst takes precedence over a press in the same cycle.
- Reset mid-operation: from any state, return to S_A with all outputs cleared. No partial result is kept.
- Arithmetic: all values are unsigned 4-bit, with no width extension. The carry is reported only via co_o.

Optional Feature:
- Macro: SUB_MODE_EN.
- Defined:
  - Adds input port sub_i (1 bit), sampled on the S_B capturing edge.
  - If sub_i=1, b_o <= (~sw + 1) mod 16, so the adder yields A−B in two's complement. co_o=1 then means no borrow.
  - ci_o remains 0.
- Undefined: port sub_i is absent and b_o <= sw unconditionally.

Test Plan (sim with DEBOUNCE_CYCLES=4, adder instantiated as DUT load):
- Reset, then press with sw=3 and press with sw=5 -> a_o=3, b_o=5; two cycles after the second pulse: res_o=8, co_o=0, zero_o=0, valid_o=1, state_o=11.
- sw=9 then sw=7 -> res_o=0, co_o=1, zero_o=1, valid_o=1; a third press -> valid_o=0, state_o=00, res_o still 0.
- btn high for 2 cycles then low (glitch) -> no pulse, state_o stays 00; btn held 100 cycles -> exactly one state advance.
- rst asserted for 1 cycle while in S_B (a_o=6) -> next cycle state_o=00, a_o=0, valid_o=0; a following press captures a new A.
- rst asserted in the same cycle as a press in S_A -> state_o=00, a_o=0.
- SUB_MODE_EN defined: A=5, B=3 with sub_i=1 -> b_o=13, res_o=2, co_o=1; A=3, B=5 with sub_i=1 -> b_o=11, res_o=14, co_o=0.
